// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: MULT/MULTU in one cycle, DIV/DIVU by radix-2 restoring division.
// Results and the write pulse come straight from posedge flops; busy stalls the pipe until the result cycle.
module muldiv_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wd,
    output logic [31:0] lo_wd
);

    localparam int W  = 32;
    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_reg;      // multiplicand, or dividend shifting out / quotient shifting in
    logic [W-1:0]    b_reg;      // multiplier or divisor magnitude
    logic [W-1:0]    rem_reg;
    logic            sgn_reg;
    logic            q_neg;
    logic            r_neg;
    logic            div0;

    logic            accept;
    logic            last_iter;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [2*W-1:0]  prod;
    logic [W:0]      r_sh;
    logic            ge;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    quo_nxt;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;

    assign accept    = (state == IDLE) && start && !flush;
    assign busy      = accept || (state == MUL) || (state == DIV);
    assign last_iter = (state == DIV) && (cnt == CW'(DIV_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = op[1] ? DIV : MUL;
            MUL:     state_nxt = IDLE;
            DIV:     if (flush || last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A 64-bit product of sign- or zero-extended operands serves both MULT and MULTU.
    always_comb begin
        a_mag   = (!op[0] && src_a[W-1]) ? -src_a : src_a;
        b_mag   = (!op[0] && src_b[W-1]) ? -src_b : src_b;
        prod    = {{W{sgn_reg & a_reg[W-1]}}, a_reg} * {{W{sgn_reg & b_reg[W-1]}}, b_reg};
        r_sh    = {rem_reg, a_reg[W-1]};
        ge      = r_sh >= {1'b0, b_reg};
        rem_nxt = ge ? (r_sh[W-1:0] - b_reg) : r_sh[W-1:0];
        quo_nxt = {a_reg[W-2:0], ge};
        q_fix   = q_neg ? -quo_nxt : quo_nxt;
        r_fix   = r_neg ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            rem_reg <= '0;
            sgn_reg <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            div0    <= 1'b0;
            hilo_we <= 1'b0;
            hi_wd   <= '0;
            lo_wd   <= '0;
        end else begin
            state   <= state_nxt;
            hilo_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        rem_reg <= '0;
                        sgn_reg <= ~op[0];
                        if (op[1]) begin
                            a_reg <= a_mag;
                            b_reg <= b_mag;
                            q_neg <= ~op[0] & (src_a[W-1] ^ src_b[W-1]);
                            r_neg <= ~op[0] & src_a[W-1];
                            div0  <= (src_b == '0);
                        end else begin
                            a_reg <= src_a;
                            b_reg <= src_b;
                        end
                    end
                end
                MUL: begin
                    if (!flush) begin
                        hilo_we <= 1'b1;
                        hi_wd   <= prod[2*W-1:W];
                        lo_wd   <= prod[W-1:0];
                    end
                end
                DIV: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        a_reg   <= quo_nxt;
                        rem_reg <= rem_nxt;
                        if (last_iter) begin
                            // With a zero divisor the remainder path reproduces |a|, so r_fix returns src_a.
                            cnt     <= '0;
                            hilo_we <= 1'b1;
                            hi_wd   <= r_fix;
                            lo_wd   <= div0 ? '1 : q_fix;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
